spi_recv_con: RTL
=================

Name: spi_recv_con

Overview:
Controller-side SPI receiver on the main FPGA, directly downstream of the camera-side peripheral sender. It synchronizes the incoming CS/DCLK/CIPO lines and samples the data lines on DCLK rising edges. Each transaction carries one pixel as DATA_WIDTH/LINES beats, MSB beat first. Each completed pixel is emitted with a one-cycle valid strobe and a sequential frame address, for the depth-map frame buffer writer.

Parameters:
DATA_WIDTH, 8, bits per pixel.
LINES, 4, parallel CIPO lines; DATA_WIDTH % LINES == 0 is required (elaboration-time check).
SYNC_STAGES, 2, flop depth of the input synchronizer (>=2).
FRAME_PIXELS, 57600, pixels per frame (320x180).
ADDR_WIDTH, $clog2(FRAME_PIXELS), width of the pixel address.
TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous, active-high reset
chip_data_in  input  LINES  CIPO lines, asynchronous
chip_clk_in  input  1  DCLK from sender, asynchronous
chip_sel_in  input  1  CS from sender, active low, asynchronous
frame_rst_in  input  1  single-cycle strobe; forces the address counter to 0
data_out  output  DATA_WIDTH  assembled pixel
data_valid_out  output  1  one-cycle strobe; data_out and addr_out are valid
addr_out  output  ADDR_WIDTH  frame address of data_out
frame_done_out  output  1  one-cycle strobe with the valid strobe of address FRAME_PIXELS-1
err_out  output  1  one-cycle protocol error strobe

Behaviour:
- Synchronizer: CS, DCLK and data each pass through SYNC_STAGES flops. Reset values: CS=1, DCLK=0, data=0. All three lines get equal delay, so data stays aligned with DCLK.
- Rise detect: rise = clk_s & ~clk_prev. clk_prev resets to 0.
- Sampling: on rise, shreg <= {shreg[DATA_WIDTH-LINES-1:0], data_s}. beat_cnt counts 0..BEATS-1, where BEATS = DATA_WIDTH/LINES.
- FSM states: IDLE, RECV, WAIT_CS. Reset state is WAIT_CS, so any transaction in flight during reset is dropped.
  - IDLE: cs_s==0 -> RECV, beat_cnt<=0. Rises seen while cs_s==1 are ignored.
  - RECV, rise on last beat: in the next cycle, data_valid_out=1, data_out=completed shreg, addr_out=current counter. The counter then increments; if it was FRAME_PIXELS-1 it wraps to 0 and frame_done_out=1. FSM -> WAIT_CS.
  - RECV, cs_s==1 before the last beat: err_out=1 next cycle, pixel discarded, counter unchanged, -> IDLE.
  - WAIT_CS: cs_s==1 -> IDLE. A rise while CS is low gives err_out=1 (overrun) and the data is ignored.
- Latency: data_valid_out is asserted exactly one clk_in cycle after the cycle in which the final synchronized rise is detected. That is SYNC_STAGES+2 cycles after the pin edge.
- Output hold: data_out and addr_out hold their last values between strobes.
- Reset values: data_out=0, data_valid_out=0, addr_out=0, frame_done_out=0, err_out=0, counter=0, beat_cnt=0.
- frame_rst_in: counter <= 0. If it coincides with a pixel completion, that pixel gets addr_out=0 and the counter becomes 1. frame_done_out is not asserted in that case.
- Sender timing constraint: DCLK half-period must be >= SYNC_STAGES+2 clk_in cycles (sender default is 50), so no edge is missed.

Optional Feature:
SPI_RECV_TIMEOUT_EN
- With the macro: a watchdog counter runs in RECV and WAIT_CS and clears on every rise and in IDLE. Reaching TIMEOUT_CYCLES-1 forces the FSM to IDLE and pulses err_out. A partial pixel is discarded and the counter is unchanged.
- Without the macro: there is no watchdog and the FSM waits indefinitely for CS high. TIMEOUT_CYCLES is unused.

Decomposition:
- Package spi_con_pkg: state enum (IDLE, RECV, WAIT_CS), and defaults for DATA_WIDTH, LINES and FRAME_PIXELS, shared with the sender.
- Sub-module: spi_input_sync, a parameterized width x SYNC_STAGES flop chain with a reset value parameter, instantiated once for {CS, DCLK, data}.

Test Plan:
- Single pixel 0xA5, LINES=4, DCLK half-period 50 cycles -> one data_valid_out pulse, data_out=0xA5, addr_out=0, err_out never high.
- Three back-to-back pixels 0x12, 0x34, 0xFE -> addr_out 0, 1, 2 with matching data.
- FRAME_PIXELS=4, five pixels sent -> frame_done_out with addr 3; fifth pixel at addr 0.
- CS raised after one rising edge -> err_out pulse, no valid; next full pixel 0x5A lands at the unchanged address.
- rst_in asserted mid-transaction with CS held low through the remaining edges -> no valid and no err. After CS goes high, a fresh pixel 0x77 is received at addr 0.
- frame_rst_in coincident with completion of pixel 0x3C at counter 10 -> addr_out=0; next pixel at addr 1.
- (With SPI_RECV_TIMEOUT_EN, TIMEOUT_CYCLES=200) CS held low with DCLK stalled after one beat -> err_out exactly 200 cycles after the last rise, FSM back in IDLE.

Source files
------------

// File: rtl/spi_con_pkg.sv
// Shared definitions for the camera-link SPI sender/receiver pair.
package spi_con_pkg;
  typedef enum logic [1:0] {IDLE, RECV, WAIT_CS} state_t;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_LINES        = 4;
  localparam int DEF_FRAME_PIXELS = 57600;
endpackage

// File: rtl/spi_input_sync.sv
// WIDTH x STAGES synchronizer chain with a per-bit reset value and a primed flag
// that rises once real pin samples have reached the output.
module spi_input_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             primed
);
  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [STAGES-1:0]            vld_pipe;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      chain    <= {STAGES{RST_VAL}};
      vld_pipe <= '0;
    end else begin
      chain    <= {chain[STAGES-2:0], d};
      vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
    end
  end

  assign q      = chain[STAGES-1];
  assign primed = vld_pipe[STAGES-1];
endmodule

// File: rtl/spi_recv_con.sv
// Controller-side SPI pixel receiver: synchronizes CS/DCLK/CIPO, assembles
// DATA_WIDTH/LINES beats per pixel, emits pixel + frame address. Optional
// watchdog enabled by defining SPI_RECV_TIMEOUT_EN.
module spi_recv_con
  import spi_con_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LINES          = DEF_LINES,
  parameter int SYNC_STAGES    = 2,
  parameter int FRAME_PIXELS   = DEF_FRAME_PIXELS,
  parameter int ADDR_WIDTH     = $clog2(FRAME_PIXELS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  frame_rst_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  frame_done_out,
  output logic                  err_out
);
  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LINES+1:0] SYNC_RST = {1'b1, {(LINES + 1){1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  if ((DATA_WIDTH % LINES) != 0 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("spi_recv_con: illegal parameter combination");
  end

  logic [LINES+1:0] syncd;
  logic             primed, cs_s, clk_s, clk_prev, rise;
  logic [LINES-1:0] data_s;

  spi_input_sync #(.WIDTH(LINES + 2), .STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST)) u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      ({chip_sel_in, chip_clk_in, chip_data_in}),
    .q      (syncd),
    .primed (primed)
  );

  assign cs_s   = syncd[LINES+1];
  assign clk_s  = syncd[LINES];
  assign data_s = syncd[LINES-1:0];
  assign rise   = primed & clk_s & ~clk_prev;

  state_t                state, state_n;
  logic [BW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  take, complete, err_n;
  // Set by reset: edges of a transaction cut by reset are dropped without error.
  logic                  quiet;

`ifdef SPI_RECV_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES)-1:0] wd;
`endif

  assign shreg_n = (shreg << LINES) | DATA_WIDTH'(data_s);

  always_comb begin
    state_n  = state;
    take     = 1'b0;
    complete = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: if (primed && !cs_s) state_n = RECV;
      RECV: begin
        if (rise) begin
          take = 1'b1;
          if (beat_cnt == BW'(BEATS - 1)) begin
            complete = 1'b1;
            state_n  = WAIT_CS;
          end
        end else if (cs_s) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_CS: begin
        if (primed && cs_s) state_n = IDLE;
        else if (rise && !quiet) err_n = 1'b1;
      end
      default: state_n = WAIT_CS;
    endcase
`ifdef SPI_RECV_TIMEOUT_EN
    if (state != IDLE && !rise && wd == ($bits(wd))'(TIMEOUT_CYCLES - 1)) begin
      state_n  = IDLE;
      err_n    = 1'b1;
      take     = 1'b0;
      complete = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= WAIT_CS;
      clk_prev       <= 1'b0;
      shreg          <= '0;
      beat_cnt       <= '0;
      cnt            <= '0;
      quiet          <= 1'b1;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      addr_out       <= '0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      state          <= state_n;
      clk_prev       <= clk_s;
      data_valid_out <= complete;
      err_out        <= err_n;
      frame_done_out <= complete && !frame_rst_in && (cnt == LAST_ADDR);
      if (state == IDLE) quiet <= 1'b0;
      if (take) shreg <= shreg_n;
      if (state == IDLE) beat_cnt <= '0;
      else if (take)     beat_cnt <= beat_cnt + 1'b1;
      if (complete) begin
        data_out <= shreg_n;
        addr_out <= frame_rst_in ? '0 : cnt;
        if (frame_rst_in)          cnt <= ADDR_WIDTH'(1);
        else if (cnt == LAST_ADDR) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
      end else if (frame_rst_in) begin
        cnt <= '0;
      end
    end
  end

`ifdef SPI_RECV_TIMEOUT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in || state == IDLE || rise || state_n == IDLE) wd <= '0;
    else                                                    wd <= wd + 1'b1;
  end
`endif
endmodule
